sd_adc: RTL and testbench

First-order sigma-delta ADC front end: the receive-side counterpart of the team's 1-bit DAC.
- Senses an external comparator (LVDS pair or external comparator) and drives a 1-bit feedback pin into an external RC integrator.
- Decimates the resulting bitstream with a windowed ones-counter into a MSBI+1-bit sample.
- Presents each sample on a valid/ready handshake for LED display or a host state machine.

---
 rtl/sd_adc_pkg.sv | 9 +
 rtl/sd_adc_if.sv | 9 +
 rtl/sd_adc_sync2.sv | 12 +
 rtl/sd_adc.sv | 84 ++++++++
 tb/tb_sd_adc.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/sd_adc_pkg.sv
// sd_adc_pkg: FSM state encodings and default width for the sigma-delta ADC.
package sd_adc_pkg;
  localparam int MSBI_DEF = 7;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;
endpackage

// File: rtl/sd_adc_if.sv
// sd_adc_if: sample output handshake (valid/ready) with sticky overrun flag.
interface sd_adc_if #(parameter int MSBI = sd_adc_pkg::MSBI_DEF);
  logic [MSBI:0] sample;
  logic valid;
  logic ready;
  logic ovr;
  modport master(output sample, valid, ovr, input ready);
  modport slave(input sample, valid, ovr, output ready);
endinterface

// File: rtl/sd_adc_sync2.sv
// sync2: generic 2-flop synchronizer, async active-low reset.
module sync2 (
  input  logic CLK_i,
  input  logic RSTn_i,
  input  logic D_i,
  output logic Q_o
);
  logic meta;
  always_ff @(posedge CLK_i or negedge RSTn_i)
    if (!RSTn_i) {Q_o, meta} <= 2'b00;
    else {Q_o, meta} <= {meta, D_i};
endmodule

// File: rtl/sd_adc.sv
// sd_adc: first-order sigma-delta ADC front end with windowed ones-count decimation.
// Optional macro SD_ADC_AVG_EN averages each result with the previous RUN result.
module sd_adc
  import sd_adc_pkg::*;
#(parameter int MSBI = MSBI_DEF) (
  input  logic CLK_i,
  input  logic RSTn_i,
  input  logic EN_i,
  input  logic CMP_i,
  output logic FB_o,
  sd_adc_if.master out
);
  localparam int W = MSBI + 1;
  state_t state;
  logic cmp_s, done, ld, last;
  logic [MSBI:0] cnt, res, sat, nxt;
  logic [W:0] acc, raw;
  sync2 u_sync (.CLK_i(CLK_i), .RSTn_i(RSTn_i), .D_i(CMP_i), .Q_o(cmp_s));
  // raw spans 0..N, so a full window of ones clips to all-ones
  always_comb begin
    last = &cnt;
    raw = acc + {{W{1'b0}}, FB_o};
    sat = raw[W] ? '1 : raw[MSBI:0];
  end
  always_ff @(posedge CLK_i or negedge RSTn_i)
    if (!RSTn_i) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      res <= '0;
      done <= 1'b0;
      FB_o <= 1'b0;
    end else begin
      FB_o <= cmp_s;
      done <= state == RUN && EN_i && last;
      if (state == IDLE || !EN_i) begin
        state <= EN_i ? SETTLE : IDLE;
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        acc <= last ? '0 : raw;
        if (last) state <= RUN;
        if (last && state == RUN) res <= sat;
      end
    end
`ifdef SD_ADC_AVG_EN
  logic [MSBI:0] prev;
  logic primed;
  logic [W:0] sum;
  always_comb begin
    sum = {1'b0, res} + {1'b0, prev};
    ld = done & primed;
    nxt = sum[W:1];
  end
  // the first RUN window after SETTLE only primes prev
  always_ff @(posedge CLK_i or negedge RSTn_i)
    if (!RSTn_i) begin
      prev <= '0;
      primed <= 1'b0;
    end else if (state == IDLE && EN_i) begin
      prev <= '0;
      primed <= 1'b0;
    end else if (done) begin
      prev <= res;
      primed <= 1'b1;
    end
`else
  always_comb begin
    ld = done;
    nxt = res;
  end
`endif
  always_ff @(posedge CLK_i or negedge RSTn_i)
    if (!RSTn_i) begin
      out.sample <= '0;
      out.valid <= 1'b0;
      out.ovr <= 1'b0;
    end else begin
      out.valid <= ld | (out.valid & ~out.ready);
      out.ovr <= (ld & out.valid & ~out.ready) | (out.ovr & ~(out.valid & out.ready));
      if (ld) out.sample <= nxt;
    end
endmodule

// File: tb/tb_sd_adc.sv
// tb_sd_adc: randomized bench for sd_adc against a window popcount reference model.
module tb_sd_adc;
  localparam int N = 256;
  localparam int SZ = 2048;
`ifdef SD_ADC_AVG_EN
  localparam int AVG = 1;
`else
  localparam int AVG = 0;
`endif
  localparam int RF = AVG;
  localparam int FL = (RF + 2) * N + 1;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, cmp = 1'b0, fb;
  int total = 0, bad = 0;
  logic cmp_a [SZ], en_a [SZ], rdy_a [SZ], v_a [SZ], o_a [SZ], f_a [SZ];
  logic [7:0] s_a [SZ];
  sd_adc_if #(.MSBI(7)) bus ();
  sd_adc #(.MSBI(7)) dut (.CLK_i(clk), .RSTn_i(rst_n), .EN_i(en), .CMP_i(cmp), .FB_o(fb), .out(bus));
  always #5 clk = ~clk;
  initial begin
    #3ms;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  function automatic int raw_of(int r);
    int s = 0;
    for (int k = (r + 1) * N + 1; k <= (r + 2) * N; k++) s += int'(cmp_a[k - 3]);
    return s;
  endfunction
  function automatic int sat_of(int r);
    return raw_of(r) > 255 ? 255 : raw_of(r);
  endfunction
  function automatic logic [7:0] exp_of(int r);
    return 8'(AVG ? (sat_of(r) + sat_of(r - 1)) / 2 : sat_of(r));
  endfunction
  function automatic int load_edge(int r);
    return (r + 2) * N + 1;
  endfunction
  task automatic clear(input logic rdy);
    for (int j = 0; j < SZ; j++) begin
      cmp_a[j] = 1'b0;
      en_a[j] = 1'b1;
      rdy_a[j] = rdy;
    end
  endtask
  task automatic fill_cnt(input int r, input int ones);
    for (int k = (r + 1) * N + 1; k <= (r + 2) * N; k++) cmp_a[k - 3] = (k - (r + 1) * N - 1) < ones;
  endtask
  task automatic fill_rand(input int r);
    int pct = $urandom_range(0, 256);
    for (int k = (r + 1) * N + 1; k <= (r + 2) * N; k++) cmp_a[k - 3] = $urandom_range(0, 255) < pct;
  endtask
  task automatic run(input int ncyc);
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      en = en_a[j];
      cmp = cmp_a[j];
      bus.ready = rdy_a[j];
      @(posedge clk);
      #1;
      v_a[j] = bus.valid;
      s_a[j] = bus.sample;
      o_a[j] = bus.ovr;
      f_a[j] = fb;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    cmp = 1'b0;
    bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset();
    do_reset();
    total += 4;
    if (fb !== 1'b0) begin bad++; $display("FAIL reset_fb got=%b exp=0", fb); end
    if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    if (bus.sample !== 8'h00) begin bad++; $display("FAIL reset_sample got=%h exp=00", bus.sample); end
    if (bus.ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", bus.ovr); end
  endtask
  task automatic test_zero();
    do_reset();
    clear(1'b1);
    run(load_edge(RF + 2) + 3);
    total++;
    if (f_a[N] !== 1'b0) begin bad++; $display("FAIL zero_fb got=%b exp=0", f_a[N]); end
    for (int r = RF; r < RF + 3; r++) begin
      int l = load_edge(r);
      total += 3;
      if (v_a[l - 1] !== 1'b0) begin bad++; $display("FAIL zero_pre_valid w=%0d got=%b exp=0", r, v_a[l - 1]); end
      if (v_a[l] !== 1'b1) begin bad++; $display("FAIL zero_valid w=%0d got=%b exp=1", r, v_a[l]); end
      if (s_a[l] !== exp_of(r)) begin bad++; $display("FAIL zero_sample w=%0d got=%h exp=%h", r, s_a[l], exp_of(r)); end
    end
  endtask
  task automatic test_ones();
    do_reset();
    clear(1'b1);
    for (int j = 10; j < SZ; j++) cmp_a[j] = 1'b1;
    run(load_edge(RF + 1) + 3);
    total += 2;
    if (f_a[11] !== 1'b0) begin bad++; $display("FAIL ones_fb_early got=%b exp=0", f_a[11]); end
    if (f_a[12] !== 1'b1) begin bad++; $display("FAIL ones_fb_latency got=%b exp=1", f_a[12]); end
    for (int r = RF; r < RF + 2; r++) begin
      int l = load_edge(r);
      total += 2;
      if (v_a[l] !== 1'b1) begin bad++; $display("FAIL ones_valid w=%0d got=%b exp=1", r, v_a[l]); end
      if (s_a[l] !== exp_of(r)) begin bad++; $display("FAIL ones_sample w=%0d got=%h exp=%h", r, s_a[l], exp_of(r)); end
    end
  endtask
  task automatic test_alt();
    do_reset();
    clear(1'b1);
    for (int j = 0; j < SZ; j++) cmp_a[j] = j[0];
    run(load_edge(RF + 1) + 3);
    for (int r = RF; r < RF + 2; r++) begin
      int l = load_edge(r);
      total += 2;
      if (v_a[l] !== 1'b1) begin bad++; $display("FAIL alt_valid w=%0d got=%b exp=1", r, v_a[l]); end
      if (s_a[l] !== exp_of(r)) begin bad++; $display("FAIL alt_sample w=%0d got=%h exp=%h", r, s_a[l], exp_of(r)); end
    end
  endtask
  task automatic test_random();
    do_reset();
    clear(1'b1);
    for (int r = 0; r < RF + 4; r++) fill_rand(r);
    run(load_edge(RF + 3) + 3);
    for (int r = RF; r < RF + 4; r++) begin
      int l = load_edge(r);
      total += 3;
      if (v_a[l - 1] !== 1'b0) begin bad++; $display("FAIL rand_pre_valid w=%0d got=%b exp=0", r, v_a[l - 1]); end
      if (v_a[l] !== 1'b1) begin bad++; $display("FAIL rand_valid w=%0d got=%b exp=1", r, v_a[l]); end
      if (s_a[l] !== exp_of(r)) begin bad++; $display("FAIL rand_sample w=%0d got=%h exp=%h", r, s_a[l], exp_of(r)); end
    end
  endtask
  task automatic test_overrun();
    int l1, l2, l3, l4;
    do_reset();
    clear(1'b0);
    fill_cnt(RF, 32);
    fill_cnt(RF + 1, 48);
    fill_rand(RF + 2);
    fill_rand(RF + 3);
    l1 = load_edge(RF);
    l2 = load_edge(RF + 1);
    l3 = load_edge(RF + 2);
    l4 = load_edge(RF + 3);
    rdy_a[l2 + 5] = 1'b1;
    rdy_a[l4] = 1'b1;
    run(l4 + 3);
    total += 12;
    if (o_a[l1] !== 1'b0) begin bad++; $display("FAIL ovr_first got=%b exp=0", o_a[l1]); end
    if (v_a[l2] !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", v_a[l2]); end
    if (o_a[l2] !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", o_a[l2]); end
    if (s_a[l2] !== exp_of(RF + 1)) begin bad++; $display("FAIL ovr_sample got=%h exp=%h", s_a[l2], exp_of(RF + 1)); end
    if (v_a[l2 + 5] !== 1'b0) begin bad++; $display("FAIL ovr_xfer_valid got=%b exp=0", v_a[l2 + 5]); end
    if (o_a[l2 + 5] !== 1'b0) begin bad++; $display("FAIL ovr_xfer_clear got=%b exp=0", o_a[l2 + 5]); end
    if (v_a[l3] !== 1'b1 || o_a[l3] !== 1'b0) begin bad++; $display("FAIL ovr_reload got=%b%b exp=10", v_a[l3], o_a[l3]); end
    if (s_a[l3] !== exp_of(RF + 2)) begin bad++; $display("FAIL ovr_reload_sample got=%h exp=%h", s_a[l3], exp_of(RF + 2)); end
    if (v_a[l4] !== 1'b1) begin bad++; $display("FAIL ovr_coinc_valid got=%b exp=1", v_a[l4]); end
    if (o_a[l4] !== 1'b0) begin bad++; $display("FAIL ovr_coinc_ovr got=%b exp=0", o_a[l4]); end
    if (s_a[l4] !== exp_of(RF + 3)) begin bad++; $display("FAIL ovr_coinc_sample got=%h exp=%h", s_a[l4], exp_of(RF + 3)); end
    if (v_a[l4 + 1] !== 1'b1) begin bad++; $display("FAIL ovr_hold_valid got=%b exp=1", v_a[l4 + 1]); end
  endtask
  task automatic test_async_reset();
    do_reset();
    clear(1'b0);
    for (int j = 0; j < SZ; j++) cmp_a[j] = 1'b1;
    run(FL + 100);
    total++;
    if (v_a[FL + 99] !== 1'b1 || f_a[FL + 99] !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b%b exp=11", v_a[FL + 99], f_a[FL + 99]); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    total += 4;
    if (fb !== 1'b0) begin bad++; $display("FAIL arst_fb got=%b exp=0", fb); end
    if (bus.valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", bus.valid); end
    if (bus.sample !== 8'h00) begin bad++; $display("FAIL arst_sample got=%h exp=00", bus.sample); end
    if (bus.ovr !== 1'b0) begin bad++; $display("FAIL arst_ovr got=%b exp=0", bus.ovr); end
    rst_n = 1'b1;
    clear(1'b1);
    for (int j = 0; j < SZ; j++) cmp_a[j] = 1'b1;
    run(FL + 3);
    total += 3;
    if (v_a[FL - 1] !== 1'b0) begin bad++; $display("FAIL arst_settle got=%b exp=0", v_a[FL - 1]); end
    if (v_a[FL] !== 1'b1) begin bad++; $display("FAIL arst_first_valid got=%b exp=1", v_a[FL]); end
    if (s_a[FL] !== exp_of(RF)) begin bad++; $display("FAIL arst_sample2 got=%h exp=%h", s_a[FL], exp_of(RF)); end
  endtask
  task automatic test_en_drop();
    logic [7:0] old;
    do_reset();
    clear(1'b0);
    for (int r = 0; r < RF + 2; r++) fill_rand(r);
    for (int j = FL + 100; j < SZ; j++) en_a[j] = 1'b0;
    run(FL + N + 20);
    old = exp_of(RF);
    total += 4;
    if (v_a[FL] !== 1'b1) begin bad++; $display("FAIL drop_first_valid got=%b exp=1", v_a[FL]); end
    if (s_a[FL + N + 10] !== old) begin bad++; $display("FAIL drop_retain_sample got=%h exp=%h", s_a[FL + N + 10], old); end
    if (v_a[FL + N + 10] !== 1'b1) begin bad++; $display("FAIL drop_retain_valid got=%b exp=1", v_a[FL + N + 10]); end
    if (o_a[FL + N + 10] !== 1'b0) begin bad++; $display("FAIL drop_no_load got=%b exp=0", o_a[FL + N + 10]); end
    clear(1'b0);
    for (int r = 0; r < RF + 1; r++) fill_rand(r);
    run(FL + 3);
    total += 4;
    if (s_a[FL - 1] !== old) begin bad++; $display("FAIL reen_settle_sample got=%h exp=%h", s_a[FL - 1], old); end
    if (o_a[FL - 1] !== 1'b0) begin bad++; $display("FAIL reen_settle_ovr got=%b exp=0", o_a[FL - 1]); end
    if (s_a[FL] !== exp_of(RF)) begin bad++; $display("FAIL reen_sample got=%h exp=%h", s_a[FL], exp_of(RF)); end
    if (o_a[FL] !== 1'b1) begin bad++; $display("FAIL reen_ovr got=%b exp=1", o_a[FL]); end
  endtask
  initial begin
    test_reset();
    test_zero();
    test_ones();
    test_alt();
    test_random();
    test_overrun();
    test_async_reset();
    test_en_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
